// File: rtl/if_pkg.sv
// Shared types and constants for the instruction fetch stage.
package if_pkg;

    typedef enum logic [1:0] {
        S_FETCH = 2'd0,
        S_HOLD  = 2'd1,
        S_KILL  = 2'd2
    } if_state_e;

    localparam int          PC_W      = 32;
    localparam int          OP_MSB    = 31;
    localparam int          OP_LSB    = 26;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

    function automatic logic [5:0] op_of(input logic [31:0] instr);
        return instr[OP_MSB:OP_LSB];
    endfunction

endpackage

// File: rtl/if_fetch_stage_if.sv
// Instruction-memory req/ack fetch bus between the fetch stage (master) and memory (slave).
interface if_fetch_stage_if;

    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;

    modport master (output imem_req, output imem_addr, input imem_ack, input imem_rdata);
    modport slave  (input imem_req, input imem_addr, output imem_ack, output imem_rdata);

endinterface

// File: rtl/if_hold_buf.sv
// One-entry buffer parking a fetched word (instr + pc4) while the decoder is stalled.
module if_hold_buf
    import if_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic            load,
    input  logic            clear,
    input  logic [PC_W-1:0] instr_in,
    input  logic [PC_W-1:0] pc4_in,
    output logic [PC_W-1:0] instr,
    output logic [PC_W-1:0] pc4,
    output logic            valid
);

    logic [PC_W-1:0] instr_q, instr_d;
    logic [PC_W-1:0] pc4_q, pc4_d;
    logic            valid_q, valid_d;

    // Next-entry selection: clear beats load.
    always_comb begin
        instr_d = instr_q;
        pc4_d   = pc4_q;
        valid_d = valid_q;
        if (clear) begin
            valid_d = 1'b0;
        end else if (load) begin
            instr_d = instr_in;
            pc4_d   = pc4_in;
            valid_d = 1'b1;
        end else begin
            valid_d = valid_q;
        end
    end

    // Entry register.
    always_ff @(posedge clk) begin
        if (rst) begin
            instr_q <= NOP_INSTR;
            pc4_q   <= 32'h0000_0000;
            valid_q <= 1'b0;
        end else begin
            instr_q <= instr_d;
            pc4_q   <= pc4_d;
            valid_q <= valid_d;
        end
    end

    assign instr = instr_q;
    assign pc4   = pc4_q;
    assign valid = valid_q;

endmodule

// File: rtl/if_fetch_stage.sv
// Instruction fetch stage: PC, req/ack fetch FSM and IF/ID register feeding the decoder.
// Optional IF_PERF_CNT_EN adds saturating fetch/stall performance counters.
module if_fetch_stage
    import if_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          PC_STEP  = 4
`ifdef IF_PERF_CNT_EN
    ,
    parameter int          CNT_W    = 16
`endif
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            stall,
    input  logic            flush,
    input  logic            branch_taken,
    input  logic [PC_W-1:0] branch_target,
    if_fetch_stage_if.master imem,
    output logic [PC_W-1:0] if_instr,
    output logic [5:0]      if_op,
    output logic [PC_W-1:0] if_pc4,
    output logic            if_valid
`ifdef IF_PERF_CNT_EN
    ,
    output logic [CNT_W-1:0] perf_fetch_cnt,
    output logic [CNT_W-1:0] perf_stall_cnt
`endif
);

    localparam logic [PC_W-1:0] PC_INC = 32'(PC_STEP);

    if_state_e       state_q, state_d;
    logic [PC_W-1:0] pc_q, pc_d;
    logic [PC_W-1:0] target_q, target_d;
    logic            req_q, req_d;
    logic [PC_W-1:0] instr_q, instr_d;
    logic [PC_W-1:0] pc4_q, pc4_d;
    logic            valid_q, valid_d;

    logic            ack_s;
    logic [PC_W-1:0] pc_inc_s;
    logic            buf_load_s, buf_clear_s, buf_valid_s;
    logic [PC_W-1:0] buf_instr_s, buf_pc4_s;

    // An ack is only meaningful while a request is outstanding.
    assign ack_s    = imem.imem_ack & req_q;
    assign pc_inc_s = pc_q + PC_INC;

    if_hold_buf u_hold_buf (
        .clk      (clk),
        .rst      (rst),
        .load     (buf_load_s),
        .clear    (buf_clear_s),
        .instr_in (imem.imem_rdata),
        .pc4_in   (pc_inc_s),
        .instr    (buf_instr_s),
        .pc4      (buf_pc4_s),
        .valid    (buf_valid_s)
    );

    // Next state, PC and IF/ID; priority branch > flush > stall > normal.
    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        target_d    = target_q;
        instr_d     = instr_q;
        pc4_d       = pc4_q;
        valid_d     = valid_q;
        buf_load_s  = 1'b0;
        buf_clear_s = 1'b0;
        if (branch_taken) begin
            valid_d = 1'b0;
            instr_d = NOP_INSTR;
            case (state_q)
                S_FETCH: begin
                    // An outstanding request cannot be retracted; park the target.
                    if (ack_s || !req_q) begin
                        pc_d = branch_target;
                    end else begin
                        target_d = branch_target;
                        state_d  = S_KILL;
                    end
                end
                S_HOLD: begin
                    buf_clear_s = 1'b1;
                    pc_d        = branch_target;
                    state_d     = S_FETCH;
                end
                S_KILL: begin
                    if (ack_s) begin
                        pc_d    = branch_target;
                        state_d = S_FETCH;
                    end else begin
                        target_d = branch_target;
                    end
                end
                default: state_d = S_FETCH;
            endcase
        end else if (flush) begin
            valid_d = 1'b0;
            instr_d = NOP_INSTR;
            case (state_q)
                S_FETCH: begin
                    if (ack_s) begin
                        pc_d = pc_inc_s;
                    end else begin
                        pc_d = pc_q;
                    end
                end
                S_HOLD: begin
                    buf_clear_s = 1'b1;
                    pc_d        = pc_inc_s;
                    state_d     = S_FETCH;
                end
                S_KILL: begin
                    if (ack_s) begin
                        pc_d    = target_q;
                        state_d = S_FETCH;
                    end else begin
                        pc_d = pc_q;
                    end
                end
                default: state_d = S_FETCH;
            endcase
        end else if (stall) begin
            case (state_q)
                S_FETCH: begin
                    if (ack_s) begin
                        buf_load_s = 1'b1;
                        state_d    = S_HOLD;
                    end else begin
                        state_d = S_FETCH;
                    end
                end
                S_HOLD: state_d = S_HOLD;
                S_KILL: begin
                    if (ack_s) begin
                        pc_d    = target_q;
                        state_d = S_FETCH;
                    end else begin
                        state_d = S_KILL;
                    end
                end
                default: state_d = S_FETCH;
            endcase
        end else begin
            // Not stalled: the decoder consumes IF/ID, so a cycle without a word is a bubble.
            valid_d = 1'b0;
            instr_d = NOP_INSTR;
            case (state_q)
                S_FETCH: begin
                    if (ack_s) begin
                        instr_d = imem.imem_rdata;
                        pc4_d   = pc_inc_s;
                        valid_d = 1'b1;
                        pc_d    = pc_inc_s;
                    end else begin
                        pc_d = pc_q;
                    end
                end
                S_HOLD: begin
                    instr_d     = buf_instr_s;
                    pc4_d       = buf_pc4_s;
                    valid_d     = buf_valid_s;
                    pc_d        = pc_inc_s;
                    buf_clear_s = 1'b1;
                    state_d     = S_FETCH;
                end
                S_KILL: begin
                    if (ack_s) begin
                        pc_d    = target_q;
                        state_d = S_FETCH;
                    end else begin
                        state_d = S_KILL;
                    end
                end
                default: state_d = S_FETCH;
            endcase
        end
        req_d = (state_d != S_HOLD);
    end

    // State, PC and IF/ID registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_FETCH;
            pc_q     <= RESET_PC;
            target_q <= 32'h0000_0000;
            req_q    <= 1'b0;
            instr_q  <= NOP_INSTR;
            pc4_q    <= 32'h0000_0000;
            valid_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            target_q <= target_d;
            req_q    <= req_d;
            instr_q  <= instr_d;
            pc4_q    <= pc4_d;
            valid_q  <= valid_d;
        end
    end

    assign imem.imem_req  = req_q;
    assign imem.imem_addr = pc_q;
    assign if_instr       = instr_q;
    assign if_op          = op_of(instr_q);
    assign if_pc4         = pc4_q;
    assign if_valid       = valid_q;

`ifdef IF_PERF_CNT_EN
    logic [CNT_W-1:0] fetch_cnt_q, fetch_cnt_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic             fetch_evt_s, stall_evt_s;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + {{(CNT_W-1){1'b0}}, 1'b1};
    endfunction

    assign fetch_evt_s = !branch_taken && !flush && !stall &&
                         ((state_q == S_FETCH && ack_s) || state_q == S_HOLD);
    assign stall_evt_s = (state_q == S_HOLD) || (req_q && !imem.imem_ack);

    // Saturating counter increments.
    always_comb begin
        fetch_cnt_d = fetch_cnt_q;
        stall_cnt_d = stall_cnt_q;
        if (fetch_evt_s) begin
            fetch_cnt_d = sat_inc(fetch_cnt_q);
        end else begin
            fetch_cnt_d = fetch_cnt_q;
        end
        if (stall_evt_s) begin
            stall_cnt_d = sat_inc(stall_cnt_q);
        end else begin
            stall_cnt_d = stall_cnt_q;
        end
    end

    // Counter registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_cnt_q <= '0;
            stall_cnt_q <= '0;
        end else begin
            fetch_cnt_q <= fetch_cnt_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign perf_fetch_cnt = fetch_cnt_q;
    assign perf_stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_if_fetch_stage.sv
// Scoreboard bench for if_fetch_stage: a latency-programmable memory responder plus a
// small reference PC model; expected IF/ID words are queued at ack and popped on delivery.
module tb_if_fetch_stage;

    logic        clk = 1'b0;
    logic        rst, stall, flush, branch_taken;
    logic [31:0] branch_target;
    logic [31:0] if_instr, if_pc4;
    logic [5:0]  if_op;
    logic        if_valid;
`ifdef IF_PERF_CNT_EN
    logic [15:0] perf_fetch_cnt, perf_stall_cnt;
`endif

    if_fetch_stage_if imem_bus ();

    if_fetch_stage dut (
        .clk           (clk),
        .rst           (rst),
        .stall         (stall),
        .flush         (flush),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .imem          (imem_bus),
        .if_instr      (if_instr),
        .if_op         (if_op),
        .if_pc4        (if_pc4),
        .if_valid      (if_valid)
`ifdef IF_PERF_CNT_EN
        ,
        .perf_fetch_cnt (perf_fetch_cnt),
        .perf_stall_cnt (perf_stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_errors = 0;
    logic [63:0] exp_q[$];
    logic [31:0] exp_pc, kill_tgt;
    logic        held, drop_next;
    int          lat, wait_cnt;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] word_of(input logic [31:0] a);
        return {a[7:2], a[27:2] ^ 26'h2A5_5A5};
    endfunction

    // One clock: drive inputs, answer memory, update model, then check the result after the edge.
    task automatic cycle(input logic st, input logic fl, input logic br, input logic [31:0] tgt);
        logic        do_ack;
        logic [63:0] e;
        check_val("req", {31'd0, imem_bus.imem_req}, {31'd0, !held});
        if (imem_bus.imem_req) check_val("addr", imem_bus.imem_addr, exp_pc);
        stall = st; flush = fl; branch_taken = br; branch_target = tgt;
        do_ack = imem_bus.imem_req && (wait_cnt >= lat);
        imem_bus.imem_ack   = do_ack;
        imem_bus.imem_rdata = do_ack ? word_of(imem_bus.imem_addr) : 32'hDEAD_BEEF;
        if (do_ack) wait_cnt = 0;
        else if (imem_bus.imem_req) wait_cnt++;
        if (br) begin
            if (held) begin void'(exp_q.pop_back()); held = 1'b0; end
            if (imem_bus.imem_req && !do_ack) begin
                kill_tgt = tgt; drop_next = 1'b1;
            end else begin
                exp_pc = tgt; drop_next = 1'b0;
            end
        end else if (do_ack) begin
            if (drop_next) begin
                exp_pc = kill_tgt; drop_next = 1'b0;
            end else if (fl) begin
                exp_pc = exp_pc + 32'd4;
            end else if (st) begin
                exp_q.push_back({word_of(exp_pc), exp_pc + 32'd4}); held = 1'b1;
            end else begin
                exp_q.push_back({word_of(exp_pc), exp_pc + 32'd4}); exp_pc = exp_pc + 32'd4;
            end
        end else if (fl && held) begin
            void'(exp_q.pop_back()); held = 1'b0; exp_pc = exp_pc + 32'd4;
        end else if (!st && held) begin
            held = 1'b0; exp_pc = exp_pc + 32'd4;
        end
        @(posedge clk);
        #1;
        if (br || fl) begin
            check_val("kill_valid", {31'd0, if_valid}, 32'd0);
            check_val("kill_instr", if_instr, 32'h0000_0000);
        end else if (!st && if_valid) begin
            if (exp_q.size() == 0) begin
                check_val("sb_underflow", 32'd0, 32'd1);
            end else begin
                e = exp_q.pop_front();
                check_val("instr", if_instr, e[63:32]);
                check_val("pc4", if_pc4, e[31:0]);
                check_val("op", {26'd0, if_op}, {26'd0, e[63:58]});
            end
        end
        imem_bus.imem_ack = 1'b0;
    endtask

    // Reset pulse, reset-value checks, then a post-reset cycle with a stray ack.
    task automatic do_reset();
        rst = 1'b1; stall = 1'b0; flush = 1'b0; branch_taken = 1'b0;
        branch_target = 32'h0000_0000;
        imem_bus.imem_ack = 1'b0; imem_bus.imem_rdata = 32'h0000_0000;
        @(posedge clk);
        #1;
        check_val("rst_req", {31'd0, imem_bus.imem_req}, 32'd0);
        check_val("rst_valid", {31'd0, if_valid}, 32'd0);
        check_val("rst_instr", if_instr, 32'h0000_0000);
        check_val("rst_op", {26'd0, if_op}, 32'd0);
        check_val("rst_pc4", if_pc4, 32'h0000_0000);
        check_val("rst_addr", imem_bus.imem_addr, 32'h0000_0000);
        rst = 1'b0;
        exp_q.delete();
        exp_pc = 32'h0000_0000; held = 1'b0; drop_next = 1'b0; wait_cnt = 0;
        imem_bus.imem_ack = 1'b1; imem_bus.imem_rdata = 32'hFFFF_FFFF;
        @(posedge clk);
        #1;
        imem_bus.imem_ack = 1'b0;
        check_val("post_rst_req", {31'd0, imem_bus.imem_req}, 32'd1);
        check_val("post_rst_addr", imem_bus.imem_addr, 32'h0000_0000);
        check_val("post_rst_valid", {31'd0, if_valid}, 32'd0);
    endtask

    initial begin
        lat = 0; kill_tgt = 32'h0000_0000;
        do_reset();

        // Zero-wait stream: pc4 = 4, 8, 12 on consecutive cycles.
        for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, 1'b0, 32'h0);
        check_val("stream_pc4", if_pc4, 32'd12);
        check_val("stream_valid", {31'd0, if_valid}, 32'd1);

        // Three-cycle latency: address held, single delivery.
        lat = 3;
        for (int i = 0; i < 5; i++) cycle(1'b0, 1'b0, 1'b0, 32'h0);

        // Stall at ack for two cycles, then release.
        lat = 0;
        cycle(1'b1, 1'b0, 1'b0, 32'h0);
        cycle(1'b1, 1'b0, 1'b0, 32'h0);
        cycle(1'b0, 1'b0, 1'b0, 32'h0);
        cycle(1'b0, 1'b0, 1'b0, 32'h0);

        // Branch while waiting: acked word dropped, fetch resumes at 0x40.
        lat = 3;
        cycle(1'b0, 1'b0, 1'b0, 32'h0);
        cycle(1'b0, 1'b0, 1'b1, 32'h0000_0040);
        for (int i = 0; i < 7; i++) cycle(1'b0, 1'b0, 1'b0, 32'h0);

        // Flush with an ack in the same cycle, fall-through continues.
        lat = 0;
        cycle(1'b0, 1'b1, 1'b0, 32'h0);
        cycle(1'b0, 1'b0, 1'b0, 32'h0);

        // Branch while parked in the hold buffer.
        cycle(1'b1, 1'b0, 1'b0, 32'h0);
        cycle(1'b0, 1'b0, 1'b1, 32'h0000_0080);
        cycle(1'b0, 1'b0, 1'b0, 32'h0);

        // Flush while parked in the hold buffer.
        cycle(1'b1, 1'b0, 1'b0, 32'h0);
        cycle(1'b1, 1'b1, 1'b0, 32'h0);
        cycle(1'b0, 1'b0, 1'b0, 32'h0);

        // PC wrap at the top of the address space.
        cycle(1'b0, 1'b0, 1'b1, 32'hFFFF_FFFC);
        cycle(1'b0, 1'b0, 1'b0, 32'h0);
        check_val("wrap_pc4", if_pc4, 32'h0000_0000);
        cycle(1'b0, 1'b0, 1'b0, 32'h0);

        // Reset in the middle of a hold.
        cycle(1'b1, 1'b0, 1'b0, 32'h0);
        cycle(1'b1, 1'b0, 1'b0, 32'h0);
        do_reset();
        lat = 1;
        for (int i = 0; i < 6; i++) cycle(1'b0, 1'b0, 1'b0, 32'h0);
        lat = 0;
        cycle(1'b0, 1'b0, 1'b0, 32'h0);
        check_val("sb_drained", exp_q.size(), 32'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
